memory_access: RTL

Load/store stage of the single-cycle MIPS core. It sits directly downstream of `execute`, taking the ALU result as the effective address and the forwarded second operand as store data. It runs a request/acknowledge transaction on the data-memory bus and handles byte lanes, sign or zero extension, and misalignment. It stalls the PC until the access completes or times out.

---
 rtl/memory_access.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access
//   Load/store stage of the single-cycle MIPS core. Turns a load or store
//   request from execute into one request/acknowledge transaction on the
//   data-memory bus. It handles byte lanes, sign/zero extension of loads
//   and misalignment detection, and it stalls the PC until the access
//   completes or times out.
//
// Ports
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_memRead/i_memWrite  load / store requested by the instruction
//   i_size                00 byte, 01 half, 10 word, 11 reserved
//   i_extOp               load extension: 1 sign, 0 zero
//   i_addr, i_wdata       effective address and store data
//   o_rdata               registered load result
//   o_stall               hold PC / instruction this cycle
//   o_misalign            illegal access presented while idle
//   o_buserr              access timed out (valid in DONE)
//   o_bus_*               registered bus request fields
//   i_bus_ack, i_bus_rdata  bus completion and read data
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [1:0]  i_size,
  input  logic        i_extOp,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_buserr,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Counter value on the last REQ cycle before the access is abandoned.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  size_q, size_d;
  logic        ext_q, ext_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        buserr_q, buserr_d;

  logic        any_req;
  logic        bad_align;
  logic        illegal;
  logic        start;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  // Request decode. Read and write together is not an access at all, but it
  // is still reported as illegal so the core can trap on it.
  always_comb begin
    any_req   = i_memRead | i_memWrite;
    bad_align = 1'b0;
    unique case (i_size)
      2'b00:   bad_align = 1'b0;
      2'b01:   bad_align = i_addr[0];
      2'b10:   bad_align = (i_addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    illegal = any_req & ((i_memRead & i_memWrite) | bad_align);
    start   = (state_q == IDLE) & (i_memRead ^ i_memWrite) & ~illegal;
  end

  // Byte enables and lane-replicated store data for the presented request.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = i_wdata;
    unique case (i_size)
      2'b00: begin
        be_new    = 4'b0001 << i_addr[1:0];
        wdata_new = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{i_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = i_wdata;
      end
    endcase
  end

  // Load data selection uses the latched lane and size, so the request inputs
  // are free to change while the bus transaction is in flight.
  always_comb begin
    byte_sel = i_bus_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    unique case (size_q)
      2'b00:   load_val = {{24{ext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{ext_q & half_sel[15]}}, half_sel};
      default: load_val = i_bus_rdata;
    endcase
  end

  // Next-state logic: every register holds unless a state below updates it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    size_d      = size_q;
    ext_d       = ext_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    buserr_d    = buserr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d    = 8'd0;
        buserr_d = 1'b0;
        if (start) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = i_memWrite;
          bus_addr_d  = {i_addr[31:2], 2'b00};
          bus_be_d    = be_new;
          bus_wdata_d = wdata_new;
          size_d      = i_size;
          ext_d       = i_extOp;
          lane_d      = i_addr[1:0];
        end
      end
      REQ: begin
        if (i_bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (!bus_we_q) rdata_d = load_val;
        end else if (cnt_q == LAST_WAIT) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          cnt_d     = 8'd0;
          buserr_d  = 1'b1;
          if (!bus_we_q) rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        cnt_d    = 8'd0;
        buserr_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase
  end

  // State and request registers; reset drops the request immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      size_q      <= 2'd0;
      ext_q       <= 1'b0;
      lane_q      <= 2'd0;
      rdata_q     <= 32'd0;
      buserr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      size_q      <= size_d;
      ext_q       <= ext_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
      buserr_q    <= buserr_d;
    end
  end

  // The IDLE cycle of a legal access already stalls, before REQ is entered.
  assign o_stall     = start | (state_q == REQ);
  assign o_misalign  = (state_q == IDLE) & illegal;
  assign o_buserr    = buserr_q;
  assign o_rdata     = rdata_q;
  assign o_bus_req   = bus_req_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_be    = bus_be_q;
  assign o_bus_wdata = bus_wdata_q;

endmodule
